// File: rtl/mux4_to_1_pkg.sv
// Shared types and helpers for the mux4_to_1 selector.
// Select encoding, default counter width and the saturating increment.
package mux4_to_1_pkg;

    typedef enum logic [1:0] {
        SEL_I0 = 2'd0,
        SEL_I1 = 2'd1,
        SEL_I2 = 2'd2,
        SEL_I3 = 2'd3
    } sel_e;

    localparam int unsigned CNT_W_DEFAULT = 16;

    // Counters up to 32 bits wide; holds at the all-ones value of the given width.
    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt >= max_val) ? max_val : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/mux4_to_1_sel_tracker.sv
// Registers the select, pulses sel_chg on a change and optionally counts changes.
// The counter is only built when MUX4_TO_1_SEL_CNT_EN is defined; otherwise it reads 0.
module mux4_to_1_sel_tracker
    import mux4_to_1_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sel_e             sel,
    output logic             sel_chg,
    output logic [CNT_W-1:0] sel_chg_cnt
);

    sel_e sel_q;
    logic sel_chg_q;
    logic changed;

    assign changed = (sel != sel_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= SEL_I0;
            sel_chg_q <= 1'b0;
        end else begin
            sel_q     <= sel;
            sel_chg_q <= changed;
        end
    end

    assign sel_chg = sel_chg_q;

`ifdef MUX4_TO_1_SEL_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = CNT_W'(cnt_sat_inc(32'(cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sel_chg_cnt = cnt_q;
`else
    assign sel_chg_cnt = '0;
`endif

endmodule

// File: rtl/mux4_to_1.sv
// 4:1 selector with a combinational output, a registered copy and select-change tracking.
// Optional change counter enabled by MUX4_TO_1_SEL_CNT_EN.
module mux4_to_1
    import mux4_to_1_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s1,
    input  logic             s0,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] sel_chg_cnt
);

    sel_e sel;

    assign sel = sel_e'({s1, s0});

    // Unknown select propagates X in simulation; the default is a don't-care for synthesis.
    always_comb begin
        case (sel)
            SEL_I0:  y = i0;
            SEL_I1:  y = i1;
            SEL_I2:  y = i2;
            SEL_I3:  y = i3;
            default: y = 'x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

    mux4_to_1_sel_tracker #(
        .CNT_W(CNT_W)
    ) u_sel_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .sel_chg    (sel_chg),
        .sel_chg_cnt(sel_chg_cnt)
    );

endmodule

// File: tb/tb_mux4_to_1.sv
// Directed self-checking bench for mux4_to_1: an 8-bit/16-bit-count instance and a
// 1-bit/2-bit-count instance share clock and reset. Honours MUX4_TO_1_SEL_CNT_EN.
module tb_mux4_to_1;

`ifdef MUX4_TO_1_SEL_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n;

    logic [7:0]  a_i0, a_i1, a_i2, a_i3, a_y, a_yq;
    logic [1:0]  a_sel;
    logic        a_chg;
    logic [15:0] a_cnt;

    logic        b_i0, b_i1, b_i2, b_i3, b_y, b_yq;
    logic [1:0]  b_sel;
    logic        b_chg;
    logic [1:0]  b_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 if (clk_en) clk = ~clk;

    mux4_to_1 #(.WIDTH(8), .CNT_W(16)) dut_a (
        .y(a_y), .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3),
        .s1(a_sel[1]), .s0(a_sel[0]), .clk(clk), .rst_n(rst_n),
        .y_q(a_yq), .sel_chg(a_chg), .sel_chg_cnt(a_cnt)
    );

    mux4_to_1 #(.WIDTH(1), .CNT_W(2)) dut_b (
        .y(b_y), .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
        .s1(b_sel[1]), .s0(b_sel[0]), .clk(clk), .rst_n(rst_n),
        .y_q(b_yq), .sel_chg(b_chg), .sel_chg_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]  b_seq [4];
        logic [1:0]  a_seq [4];
        logic        chg_exp [4];
        logic [7:0]  v;
        int unsigned cnt_exp;

        b_seq   = '{2'b00, 2'b01, 2'b10, 2'b11};
        a_seq   = '{2'b00, 2'b01, 2'b01, 2'b11};
        chg_exp = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        a_i0 = 8'h11; a_i1 = 8'h22; a_i2 = 8'h33; a_i3 = 8'h44; a_sel = 2'b00;
        b_i0 = 1'b0;  b_i1 = 1'b1;  b_i2 = 1'b0;  b_i3 = 1'b1;  b_sel = 2'b00;
        #1;
        check("rst_yq",  32'(a_yq),  32'h0);
        check("rst_chg", 32'(a_chg), 32'h0);
        check("rst_cnt", 32'(a_cnt), 32'h0);

        // Static selection with no clock running
        for (int k = 0; k < 4; k++) begin
            b_sel = b_seq[k];
            #10;
            check($sformatf("static_y_sel%0d", k), 32'(b_y), 32'(k % 2));
        end
        b_sel = 2'b00;

        rst_n = 1'b1;
        a_sel = 2'b10;
        #1;
        check("w8_y_immediate", 32'(a_y), 32'h33);
        clk_en = 1'b1;
        step();
        check("w8_yq", 32'(a_yq), 32'h33);
        check("w8_chg", 32'(a_chg), 32'h1);
        check("w8_cnt", 32'(a_cnt), CntEn ? 32'd1 : 32'd0);
        step();
        check("w8_chg_clear", 32'(a_chg), 32'h0);

        // Build up count 5 ending on i3 = 0x44
        a_sel = 2'b11; step();
        a_sel = 2'b01; step();
        a_sel = 2'b10; step();
        a_sel = 2'b11; step();
        check("pre_rst_yq",  32'(a_yq),  32'h44);
        check("pre_rst_cnt", 32'(a_cnt), CntEn ? 32'd5 : 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_yq",  32'(a_yq),  32'h0);
        check("async_rst_cnt", 32'(a_cnt), 32'h0);
        check("async_rst_chg", 32'(a_chg), 32'h0);
        check("rst_y_follows", 32'(a_y),   32'h44);
        a_i3 = 8'h55;
        #1;
        check("rst_y_follows2", 32'(a_y), 32'h55);
        #3;
        rst_n = 1'b1;
        step();
        check("post_rst_chg", 32'(a_chg), 32'h1);
        check("post_rst_cnt", 32'(a_cnt), CntEn ? 32'd1 : 32'd0);
        check("post_rst_yq",  32'(a_yq),  32'h55);

        // Select sequence 00,01,01,11 from a clean reset
        a_sel = 2'b00;
        b_sel = 2'b00;
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            a_sel = a_seq[k];
            step();
            check($sformatf("seq_chg%0d", k), 32'(a_chg), 32'(chg_exp[k]));
        end
        check("seq_cnt", 32'(a_cnt), CntEn ? 32'd2 : 32'd0);
        check("seq_b_cnt_idle", 32'(b_cnt), 32'h0);

        // Saturation on the 2-bit counter
        for (int k = 0; k < 6; k++) begin
            b_sel = (k % 2 == 0) ? 2'b01 : 2'b00;
            step();
            cnt_exp = (k + 1 > 3) ? 3 : k + 1;
            check($sformatf("sat_cnt%0d", k), 32'(b_cnt), CntEn ? cnt_exp : 32'd0);
            check($sformatf("sat_chg%0d", k), 32'(b_chg), 32'h1);
        end

        // Data-only changes with select held
        a_sel = 2'b01;
        step();
        for (int k = 0; k < 10; k++) begin
            v = (k % 2 == 0) ? 8'hA5 : 8'h5A;
            a_i1 = v;
            #1;
            check($sformatf("data_y%0d", k), 32'(a_y), 32'(v));
            step();
            check($sformatf("data_yq%0d", k), 32'(a_yq), 32'(v));
            check($sformatf("data_chg%0d", k), 32'(a_chg), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux4_to_1.md
# mux4_to_1

Four-input, one-output selector with a 2-bit select split into `s1`/`s0`. It presents `y` combinationally so that existing unclocked users keep zero-latency selection, and adds a registered copy of the output plus select-change tracking for clocked consumers. It is a leaf datapath block instantiated wherever a 4:1 steering point is needed.

## Interface
Parameters:
- `WIDTH`, default 1: data width of `i0`..`i3`, `y` and `y_q`.
- `CNT_W`, default 16: width of `sel_chg_cnt`.

Ports are declared in the order `y, i0, i1, i2, i3, s1, s0, clk, rst_n`, which keeps existing positional instantiations valid:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `y` output WIDTH: combinational selected data.
- `i0`..`i3` input WIDTH: data inputs.
- `s1` input 1: select MSB.
- `s0` input 1: select LSB.
- `y_q` output WIDTH: registered `y`.
- `sel_chg` output 1: one-cycle pulse when the select changed.
- `sel_chg_cnt` output CNT_W: saturating count of select changes.

## Operation
- Let `sel = {s1,s0}`. Output mapping: 00→`i0`, 01→`i1`, 10→`i2`, 11→`i3`.
- `y` is purely combinational and has no dependency on `clk` or `rst_n`.
- If `sel` contains X or Z, `y` is driven all-X in simulation. Synthesis must not add any logic for this case.
- `y_q` samples `y` every rising edge.
- `sel_q` is an internal 2-bit register of `sel`, reset to 00.
- `sel_chg` is a register set to `(sel != sel_q)` each cycle.
- `sel_chg_cnt` increments by 1 on each cycle where `sel != sel_q`. It saturates at 2^CNT_W−1 and does not wrap.
- Reset values: `y_q` = 0, `sel_q` = 00, `sel_chg` = 0, `sel_chg_cnt` = 0. `y` is unaffected by reset.
- Reset asserted mid-operation clears all registers immediately, without waiting for a clock edge. On the first edge after deassertion, any select other than 00 counts as a change.

## Timing
- `y`: zero-cycle latency. It must settle within a combinational path from `i*`/`s*`.
- `y_q`: one-cycle latency from `y`.
- `sel_chg`: asserts in the cycle after the edge at which the new select was first sampled. It lasts exactly one cycle per change.
- Back-to-back changes on consecutive edges produce consecutive `sel_chg` pulses, and the count advances by 1 each cycle.
- Data-only changes, with `sel` stable, never assert `sel_chg`.
- No handshake; the block accepts new inputs every cycle.

## Configuration
- Macro: `MUX4_TO_1_SEL_CNT_EN`.
- Defined: the `sel_chg_cnt` counter is built as described above.
- Undefined: no counter register is built and `sel_chg_cnt` is tied to 0.
- In both builds `y`, `y_q` and `sel_chg` behave identically, and the port list is unchanged.

## Structure
- Package `mux4_to_1_pkg` holds:
  - the 2-bit select enum `SEL_I0`=0, `SEL_I1`=1, `SEL_I2`=2, `SEL_I3`=3;
  - the default `CNT_W` constant;
  - the function `cnt_sat_inc`.
- One sub-module, `mux4_to_1_sel_tracker`. It owns `sel_q`, `sel_chg` and the optional counter. Its inputs are `clk`, `rst_n` and `sel`.
- The top level holds the combinational mux and the `y_q` register.

## Test plan
- Static vectors, WIDTH=1, `i0`=0, `i1`=1, `i2`=0, `i3`=1, no clock toggling. Sel 00, 01, 10, 11 held 10 ns each → `y` = 0, 1, 0, 1.
- WIDTH=8 with `i0`=0x11, `i1`=0x22, `i2`=0x33, `i3`=0x44, sel=10 → `y`=0x33 immediately, and `y_q`=0x33 after one rising edge.
- Reset: drive `rst_n`=0 mid-cycle with `y_q`=0x44 and count=5 → `y_q`=0 and count=0 without a clock edge, while `y` still follows the inputs.
- Sel sequence 00, 01, 01, 11 on consecutive edges → `sel_chg` = 0, 1, 0, 1 one cycle later. With the macro, count ends at 2; without it, count stays 0.
- Saturation with CNT_W=2: toggle sel every cycle for 6 cycles → count reads 1, 2, 3, 3, 3, 3.
- Data-only change: sel held at 01 while `i1` toggles 10 times → `sel_chg` stays 0, and `y`/`y_q` track `i1`.
